// File: rtl/argon_pkg.sv
// Shared widths and the write-back entry type for the Argon register file writer.
package argon_pkg;

  localparam int ARGON_REGISTERS  = 8;
  localparam int ARGON_INDEXWIDTH = 3;
  localparam int ARGON_DATAWIDTH  = 16;
  localparam int ARGON_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ARGON_INDEXWIDTH-1:0] rd;
    logic [ARGON_DATAWIDTH-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/argon_sync_fifo.sv
// Small synchronous FIFO holding memory results until the write port is free.
module argon_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/argon_writeback.sv
// Argon write-side driver: ALU/memory result arbitration, registered regfile write, hazard scoreboard.
module argon_writeback
  import argon_pkg::*;
#(
  parameter int REGISTERS  = ARGON_REGISTERS,
  parameter int INDEXWIDTH = ARGON_INDEXWIDTH,
  parameter int DATAWIDTH  = ARGON_DATAWIDTH,
  parameter int FIFO_DEPTH = ARGON_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_issue_valid,
  input  logic [INDEXWIDTH-1:0] i_issue_rd,
  input  logic                  i_alu_valid,
  input  logic [INDEXWIDTH-1:0] i_alu_rd,
  input  logic [DATAWIDTH-1:0]  i_alu_data,
  input  logic                  i_mem_valid,
  output logic                  o_mem_ready,
  input  logic [INDEXWIDTH-1:0] i_mem_rd,
  input  logic [DATAWIDTH-1:0]  i_mem_data,
  input  logic [INDEXWIDTH-1:0] i_query_a,
  input  logic [INDEXWIDTH-1:0] i_query_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_writeEn,
  output logic [INDEXWIDTH-1:0] o_selectW,
  output logic [DATAWIDTH-1:0]  o_wdata,
  output logic                  o_spurious
);

  wb_entry_t             head;
  wb_entry_t             win;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  mem_push;
  logic                  mem_pop;
  logic                  win_write;
  logic [REGISTERS-1:0]  pend;
  logic [REGISTERS-1:0]  pend_next;

  assign o_mem_ready = i_reset_n && !fifo_full;
  assign mem_push    = i_mem_valid && o_mem_ready;
  assign mem_pop     = !i_alu_valid && !fifo_empty;

  argon_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk       (i_clk),
    .reset_n   (i_reset_n),
    .push      (mem_push),
    .push_data ({i_mem_rd, i_mem_data}),
    .pop       (mem_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ALU always wins; rd==0 results are consumed but never reach the port.
  always_comb begin
    win       = '0;
    win_write = 1'b0;
    if (i_alu_valid) begin
      win       = '{rd: i_alu_rd, data: i_alu_data};
      win_write = (i_alu_rd != '0);
    end else if (!fifo_empty) begin
      win       = head;
      win_write = (head.rd != '0);
    end
  end

  // Clear on the commit edge first so a same-edge issue to that index keeps it pending.
  always_comb begin
    pend_next = pend;
    if (o_writeEn) pend_next[o_selectW] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) pend_next[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_writeEn  <= 1'b0;
      o_selectW  <= '0;
      o_wdata    <= '0;
      o_spurious <= 1'b0;
      pend       <= '0;
    end else begin
      o_writeEn <= win_write;
      pend      <= pend_next;
      if (win_write) begin
        o_selectW <= win.rd;
        o_wdata   <= win.data;
        if (!pend[win.rd]) o_spurious <= 1'b1;
      end
    end
  end

  assign o_busy_a = (i_query_a != '0) && pend[i_query_a];
  assign o_busy_b = (i_query_b != '0) && pend[i_query_b];

endmodule
